// File: rtl/sample_frame_tx_pkg.sv
// Shared constants and types for the sample frame transmitter.
package sample_frame_tx_pkg;

    localparam int SAMPLE_W         = 3;
    localparam int SAMPLES_PER_WORD = 5;
    localparam int WORD_W           = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } tx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sample_frame_tx_sync_fifo.sv
// Purpose: first-word-fall-through word FIFO with occupancy count and drop flag.
// Latency: a push is visible at the head and in count one cycle after its edge.
// Backpressure: push on full is dropped unless a pop happens in the same cycle.
module sample_frame_tx_sync_fifo #(
    parameter int W  = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          push_drop
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign rd_en     = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign wr_en     = push && (!full || rd_en);
    assign push_drop = push && !wr_en;
    assign head_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_frame_tx.sv
// Purpose: packs 3-bit samples into 16-bit words and emits seq-header framed bursts; SAMPLE_TX_DEBUG_EN enables debug counters.
// Latency: word counted one cycle after its 5th sample edge; header valid one cycle after threshold met.
// Backpressure: valid/ready output, outputs held while stalled; full FIFO drops incoming words.
module sample_frame_tx
    import sample_frame_tx_pkg::*;
#(
    parameter int PAYLOAD_WORDS = 256,
    parameter int FIFO_AW       = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic [2:0]         sample,
    input  logic               halt,
    output logic [15:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eof,
    output logic [FIFO_AW:0]   words_available,
    output logic [15:0]        overflow_count,
    output logic [15:0]        frame_count
);
    localparam logic [FIFO_AW:0] PAY_THR  = (FIFO_AW+1)'(PAYLOAD_WORDS);
    localparam logic [FIFO_AW:0] PAY_LAST = (FIFO_AW+1)'(PAYLOAD_WORDS - 1);

    // ---------------- packer ----------------
    logic        sample_acc;
    logic [2:0]  pk_idx;
    logic [11:0] pk_bits;
    logic        push_vld;
    word_t       push_dat;

    assign sample_acc = sample_valid && !halt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pk_idx   <= '0;
            pk_bits  <= '0;
            push_vld <= 1'b0;
            push_dat <= '0;
        end else begin
            push_vld <= 1'b0;
            if (sample_acc) begin
                if (pk_idx == 3'(SAMPLES_PER_WORD - 1)) begin
                    push_vld <= 1'b1;
                    push_dat <= {1'b0, sample, pk_bits};
                    pk_idx   <= '0;
                end else begin
                    case (pk_idx)
                        3'd0:    pk_bits[2:0]  <= sample;
                        3'd1:    pk_bits[5:3]  <= sample;
                        3'd2:    pk_bits[8:6]  <= sample;
                        default: pk_bits[11:9] <= sample;
                    endcase
                    pk_idx <= pk_idx + 3'd1;
                end
            end
        end
    end

    // ---------------- word FIFO ----------------
    logic        fifo_pop;
    word_t       fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    sample_frame_tx_sync_fifo #(
        .W  (WORD_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_vld),
        .push_dat  (push_dat),
        .pop       (fifo_pop),
        .head_dat  (fifo_head),
        .count     (words_available),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (fifo_drop)
    );

    // ---------------- framing FSM ----------------
    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [FIFO_AW:0] pay_cnt;
    logic [15:0]      seq;
    logic             pay_last;
    logic             frame_done;

    assign pay_last   = (pay_cnt == PAY_LAST);
    assign frame_done = (state == ST_PAYLOAD) && out_ready && pay_last;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        out_data  = '0;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A frame starts only with its whole payload buffered.
                if (words_available >= PAY_THR) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                out_valid = 1'b1;
                out_sof   = 1'b1;
                out_data  = seq;
                if (out_ready) state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                out_valid = 1'b1;
                out_eof   = pay_last;
                out_data  = fifo_head;
                if (out_ready) begin
                    fifo_pop = 1'b1;
                    if (pay_last) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            pay_cnt <= '0;
            seq     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_HEADER && out_ready) begin
                pay_cnt <= '0;
            end else if (state == ST_PAYLOAD && out_ready) begin
                pay_cnt <= pay_cnt + 1'b1;
            end
            if (frame_done) seq <= seq + 16'd1;
        end
    end

    // ---------------- debug counters ----------------
`ifdef SAMPLE_TX_DEBUG_EN
    logic [15:0] ovf_q;
    logic [15:0] frm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
            frm_q <= '0;
        end else begin
            if (fifo_drop)  ovf_q <= sat_inc16(ovf_q);
            if (frame_done) frm_q <= sat_inc16(frm_q);
        end
    end

    assign overflow_count = ovf_q;
    assign frame_count    = frm_q;
    wire unused_flags = fifo_full ^ fifo_empty;
`else
    assign overflow_count = '0;
    assign frame_count    = '0;
    wire unused_flags = fifo_drop ^ frame_done ^ fifo_full ^ fifo_empty;
`endif

endmodule

// File: tb/tb_sample_frame_tx.sv
// Bench for sample_frame_tx: queue-based frame model checked every cycle, plus literal pins.
module tb_sample_frame_tx;
    localparam int P   = 4;
    localparam int AW  = 3;
    localparam int CAP = 1 << AW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [2:0]  sample = 3'd0;
    logic        halt = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic [AW:0] words_available;
    logic [15:0] overflow_count;
    logic [15:0] frame_count;

    always #10 clk = ~clk;

    sample_frame_tx #(.PAYLOAD_WORDS(P), .FIFO_AW(AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sample_valid    (sample_valid),
        .sample          (sample),
        .halt            (halt),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sof         (out_sof),
        .out_eof         (out_eof),
        .words_available (words_available),
        .overflow_count  (overflow_count),
        .frame_count     (frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dbg(input int v);
`ifdef SAMPLE_TX_DEBUG_EN
        return 16'(v);
`else
        return 16'(v) & 16'h0000;
`endif
    endfunction

    // ---------------- reference model ----------------
    int          samp_q[$];
    logic [15:0] fq[$];
    logic [15:0] log_q[$];
    logic        pend_vld = 1'b0;
    logic [15:0] pend_word = '0;
    int          pos = -1;          // -1 idle, 0 header, 1..P payload word index
    logic [15:0] m_seq = '0;
    int          m_ovf = 0;
    int          m_frm = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            samp_q.delete();
            fq.delete();
            pend_vld = 1'b0;
            pos      = -1;
            m_seq    = '0;
            m_ovf    = 0;
            m_frm    = 0;
            check("rst_valid", out_valid, 0);
            check("rst_sof", out_sof, 0);
            check("rst_eof", out_eof, 0);
            check("rst_data", out_data, 0);
            check("rst_words", words_available, 0);
            check("rst_ovf", overflow_count, 0);
            check("rst_frm", frame_count, 0);
        end else begin
            logic        ev;
            logic [15:0] ed;
            logic        hs;
            int          occ;
            ev = (pos >= 0);
            ed = (pos < 0) ? 16'h0 : (pos == 0) ? m_seq : fq[0];
            check("valid", out_valid, ev);
            check("data", out_data, ed);
            check("sof", out_sof, pos == 0);
            check("eof", out_eof, pos == P);
            check("words", words_available, fq.size());
            check("ovf", overflow_count, dbg(m_ovf));
            check("frm", frame_count, dbg(m_frm));

            hs  = ev && out_ready;
            occ = fq.size();
            if (hs) log_q.push_back(out_data);
            if (hs && pos >= 1) void'(fq.pop_front());
            if (pend_vld) begin
                if (fq.size() < CAP) fq.push_back(pend_word);
                else if (m_ovf < 65535) m_ovf++;
            end
            if (pos < 0) begin
                if (occ >= P) pos = 0;
            end else if (hs) begin
                if (pos == P) begin
                    pos   = -1;
                    m_seq = m_seq + 16'd1;
                    if (m_frm < 65535) m_frm++;
                end else begin
                    pos++;
                end
            end
            pend_vld = 1'b0;
            if (sample_valid && !halt) begin
                samp_q.push_back(int'(sample));
                if (samp_q.size() == 5) begin
                    int w;
                    w = 0;
                    for (int k = 0; k < 5; k++) w += samp_q[k] << (3 * k);
                    pend_word = 16'(w);
                    pend_vld  = 1'b1;
                    samp_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s);
        sample_valid = 1'b1;
        sample       = s;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = (pos < 0) && (fq.size() < P) && !pend_vld;
        end
        check("drain_done", done, 1);
    endtask

    task automatic check_frame(input string name, input logic [15:0] hdr);
        logic [15:0] exp_w [5];
        exp_w[0] = hdr;
        exp_w[1] = 16'h4688;
        exp_w[2] = 16'h11F5;
        exp_w[3] = 16'h6B1A;
        exp_w[4] = 16'h3447;
        check({name, "_len"}, log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            check($sformatf("%s_w%0d", name, i), log_q[i], exp_w[i]);
        log_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // directed frame: samples 0..7 repeating
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(3'(i % 8));
        drain(100);
        check_frame("frame0", 16'h0000);

        // halt in the middle of a word must not disturb packing
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                halt = 1'b1;
                for (int h = 0; h < 10; h++) begin
                    sample_valid = 1'b1;
                    sample       = 3'($urandom_range(0, 7));
                    step();
                end
                sample_valid = 1'b0;
                halt         = 1'b0;
            end
            send(3'(i % 8));
        end
        drain(100);
        check_frame("frame1", 16'h0001);
        check("frm_after2", frame_count, dbg(2));

        // overflow: 10 words into an 8-deep FIFO while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) send(3'($urandom_range(0, 7)));
        repeat (3) step();
        check("ovf_words", words_available, CAP);
        check("ovf_count", overflow_count, dbg(2));
        check("ovf_stall_sof", out_sof, 1);
        check("ovf_no_hs", log_q.size(), 0);

        // toggling ready drains two frames
        for (int c = 0; c < 60; c++) begin
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b1;
        drain(50);
        check("tog_len", log_q.size(), 2 * (P + 1));
        if (log_q.size() == 2 * (P + 1)) begin
            check("tog_hdr0", log_q[0], 16'h0002);
            check("tog_hdr1", log_q[P + 1], 16'h0003);
        end
        log_q.delete();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            sample       = 3'($urandom_range(0, 7));
            halt         = ($urandom_range(0, 7) == 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            step();
        end
        sample_valid = 1'b0;
        halt         = 1'b0;
        out_ready    = 1'b1;
        drain(200);
        log_q.delete();

        // reset in the middle of a payload
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(3'(i % 8));
        for (int c = 0; c < 20 && pos != 0; c++) step();
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        check("mid_in_payload", out_valid && !out_sof, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_words", words_available, 0);
        repeat (2) step();
        reset_n = 1'b1;
        log_q.delete();
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(3'(i % 8));
        drain(100);
        check_frame("post_rst", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
